// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: instruction encodings, register-field positions
// and the fetch FSM state type.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2
    } if_state_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register for an instruction fetched while decode is stalled.
// Clear has priority over load.
module if_skid_buf
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [31:0]       instr_in,
    input  logic [ADDR_W-1:0] pc4_in,
    output logic              full,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc4
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            full  <= 1'b0;
            instr <= NOP_INSTR;
            pc4   <= '0;
        end else if (load) begin
            full  <= 1'b1;
            instr <= instr_in;
            pc4   <= pc4_in;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID pipeline register, imem req/ack handshake,
// load-use hold and branch/jump redirect with flush.
//
// state | meaning
// IDLE  | first cycle after reset; no request, any ack ignored
// FETCH | request at pc (suppressed while the skid buffer is full)
// WAIT  | request outstanding; req/addr held until ack
module if_stage
    import mips_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bubble,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc4,
    output logic              if_id_valid,
    output logic [4:0]        id_rs,
    output logic [4:0]        id_rt
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    if_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, addr_q, pc_plus4;
    logic              drop_q, drop_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;
    logic              valid_q, valid_d;
    logic              skid_full, skid_load, skid_clear;
    logic [31:0]       skid_instr;
    logic [ADDR_W-1:0] skid_pc4;
    logic              take, good;

    assign pc_plus4  = pc_q + ADDR_W'(4);
    assign imem_req  = ((state_q == FETCH) && !skid_full) || (state_q == WAIT);
    assign imem_addr = (state_q == WAIT) ? addr_q : pc_q;
    assign take      = imem_req && imem_ack;
    // an ack for a request issued before a redirect carries a stale instruction
    assign good      = take && !drop_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;

        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (imem_req && !imem_ack) state_d = WAIT;
            WAIT:    if (imem_ack) state_d = FETCH;
            default: state_d = IDLE;
        endcase

        if (take) drop_d = 1'b0;

        if (redirect) begin
            pc_d       = redirect_pc & ALIGN_MASK;
            instr_d    = NOP_INSTR;
            pc4_d      = '0;
            valid_d    = 1'b0;
            skid_clear = 1'b1;
            if (imem_req && !imem_ack) drop_d = 1'b1;
        end else if (bubble) begin
            if (good) skid_load = 1'b1;
        end else if (skid_full) begin
            instr_d    = skid_instr;
            pc4_d      = skid_pc4;
            valid_d    = 1'b1;
            skid_clear = 1'b1;
            pc_d       = pc_plus4;
        end else if (good) begin
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_VECTOR & ALIGN_MASK;
            addr_q  <= '0;
            drop_q  <= 1'b0;
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            if ((state_q == FETCH) && imem_req && !imem_ack) addr_q <= pc_q;
        end
    end

    if_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .clear    (skid_clear),
        .instr_in (imem_rdata),
        .pc4_in   (pc_plus4),
        .full     (skid_full),
        .instr    (skid_instr),
        .pc4      (skid_pc4)
    );

    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign id_rs       = instr_q[RS_MSB:RS_LSB];
    assign id_rt       = instr_q[RT_MSB:RT_LSB];

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed handshake/hazard scenarios, then a random
// memory-latency / bubble / redirect run against a transaction-level model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst, bubble, redirect, imem_ack, imem_req;
    logic [31:0] redirect_pc, imem_addr, imem_rdata, if_id_instr, if_id_pc4;
    logic        if_id_valid;
    logic [4:0]  id_rs, id_rt;

    int compared   = 0;
    int mismatched = 0;

    // model state
    logic [31:0] m_pc, m_instr, m_pc4, m_sk_instr, m_sk_pc4, m_out_addr;
    logic        m_valid, m_sk_full, m_drop, m_idle, m_out;
    logic        mem_busy, req_obs, completes;
    logic [31:0] addr_obs;
    int          lat;

    if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .bubble      (bubble),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic valid);
        check({tag, "_instr"}, if_id_instr, instr);
        check({tag, "_pc4"},   if_id_pc4,   pc4);
        check({tag, "_valid"}, 32'(if_id_valid), 32'(valid));
        check({tag, "_rs"},    32'(id_rs), 32'(instr[25:21]));
        check({tag, "_rt"},    32'(id_rt), 32'(instr[20:16]));
    endtask

    task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
        check({tag, "_req"}, 32'(imem_req), 32'(req));
        if (req) check({tag, "_addr"}, imem_addr, addr);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[17:2]};
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        m_sk_full = 1'b0; m_sk_instr = 32'h0; m_sk_pc4 = 32'h0;
        m_drop = 1'b0; m_idle = 1'b1; m_out = 1'b0; m_out_addr = 32'h0;
        mem_busy = 1'b0; lat = 0;
    endtask

    initial begin
        rst = 1'b1; bubble = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        step(); step();
        check_ifid("reset", 32'h0, 32'h0, 1'b0);
        check_req("reset", 1'b0, 32'h0);

        // zero-wait memory from reset
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h8C22_0004;
        step();
        check_req("idle_to_fetch", 1'b1, 32'h0);
        check_ifid("idle_ack_ignored", 32'h0, 32'h0, 1'b0);
        step();
        check_ifid("zero_wait", 32'h8C22_0004, 32'h4, 1'b1);
        check_req("zero_wait_next", 1'b1, 32'h4);

        // two-cycle latency
        imem_ack = 1'b0;
        step();
        check_req("wait1", 1'b1, 32'h4);
        check_ifid("wait1_hold", 32'h8C22_0004, 32'h4, 1'b1);
        step();
        check_req("wait2", 1'b1, 32'h4);
        check_ifid("wait2_hold", 32'h8C22_0004, 32'h4, 1'b1);
        imem_ack = 1'b1; imem_rdata = 32'h2408_0005;
        step();
        check_ifid("wait_done", 32'h2408_0005, 32'h8, 1'b1);
        check_req("wait_done_next", 1'b1, 32'h8);

        // bubble with ack captured into the skid buffer
        bubble = 1'b1; imem_rdata = 32'h0043_0820;
        step();
        imem_ack = 1'b0;
        check_ifid("bubble1_hold", 32'h2408_0005, 32'h8, 1'b1);
        check_req("bubble1_noreq", 1'b0, 32'h0);
        step();
        check_ifid("bubble2_hold", 32'h2408_0005, 32'h8, 1'b1);
        check_req("bubble2_noreq", 1'b0, 32'h0);
        bubble = 1'b0;
        step();
        check_ifid("skid_release", 32'h0043_0820, 32'hC, 1'b1);
        check("skid_rs", 32'(id_rs), 32'd2);
        check("skid_rt", 32'(id_rt), 32'd3);
        check_req("skid_resume", 1'b1, 32'hC);

        // redirect while a request is outstanding
        step();
        check_req("pre_redirect_wait", 1'b1, 32'hC);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        check_ifid("redirect_flush", 32'h0, if_id_pc4, 1'b0);
        check_req("redirect_held", 1'b1, 32'hC);
        redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        check_ifid("dropped_ack", 32'h0, if_id_pc4, 1'b0);
        check_req("redirect_target", 1'b1, 32'h0000_0100);
        imem_rdata = 32'h1111_1111;
        step();
        check_ifid("after_redirect", 32'h1111_1111, 32'h104, 1'b1);

        // redirect and bubble together, landing on the top of the address space
        redirect = 1'b1; bubble = 1'b1; redirect_pc = 32'hFFFF_FFFE; imem_rdata = 32'h5555_5555;
        step();
        check_ifid("redir_bubble", 32'h0, if_id_pc4, 1'b0);
        check_req("redir_bubble_pc", 1'b1, 32'hFFFF_FFFC);
        redirect = 1'b0; bubble = 1'b0; imem_rdata = 32'h2222_2222;
        step();
        check_ifid("pc_wrap", 32'h2222_2222, 32'h0, 1'b1);
        check_req("pc_wrap_next", 1'b1, 32'h0);

        // reset in the middle of a wait
        imem_ack = 1'b0;
        step();
        rst = 1'b1;
        step();
        check_ifid("reset_mid_wait", 32'h0, 32'h0, 1'b0);
        check_req("reset_mid_wait", 1'b0, 32'h0);
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h3333_3333;
        step();
        check_ifid("post_reset_ack", 32'h0, 32'h0, 1'b0);
        check_req("post_reset_fetch", 1'b1, 32'h0);
        imem_ack = 1'b0;

        // random phase
        rst = 1'b1;
        step();
        model_reset();
        rst = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            check_req("rnd", !m_idle && !m_sk_full, m_out ? m_out_addr : m_pc);
            check_ifid("rnd", m_instr, m_pc4, m_valid);

            rst      = ($urandom_range(0, 299) == 0);
            bubble   = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else                           redirect_pc = $urandom & 32'h0000_0FFF;
            req_obs  = imem_req;
            addr_obs = imem_addr;
            imem_ack = 1'b0;
            imem_rdata = $urandom;
            if (req_obs) begin
                if (!mem_busy) begin
                    mem_busy = 1'b1;
                    lat = $urandom_range(0, 2);
                end
                if (lat == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(addr_obs);
                    mem_busy   = 1'b0;
                end else begin
                    lat--;
                end
            end
            step();

            if (rst) begin
                model_reset();
            end else begin
                completes = req_obs && imem_ack;
                if (redirect) begin
                    m_pc = redirect_pc & 32'hFFFF_FFFC;
                    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_sk_full = 1'b0;
                    if (req_obs && !imem_ack) m_drop = 1'b1;
                    else if (completes)       m_drop = 1'b0;
                end else if (completes && m_drop) begin
                    m_drop = 1'b0;
                end else if (bubble) begin
                    if (completes) begin
                        m_sk_full = 1'b1;
                        m_sk_instr = mem_word(addr_obs);
                        m_sk_pc4 = addr_obs + 32'd4;
                    end
                end else if (m_sk_full) begin
                    m_instr = m_sk_instr; m_pc4 = m_sk_pc4; m_valid = 1'b1;
                    m_sk_full = 1'b0;
                    m_pc = m_pc + 32'd4;
                end else if (completes) begin
                    m_instr = mem_word(addr_obs); m_pc4 = addr_obs + 32'd4; m_valid = 1'b1;
                    m_pc = addr_obs + 32'd4;
                end
                m_idle     = 1'b0;
                m_out      = req_obs && !imem_ack;
                m_out_addr = addr_obs;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
